calendar_date_counter: RTL

- Registered day/month/year counter that produces "today" for the downstream tomorrow/last-day logic and advances the date once per day.
- It supplies the current day (5-bit) and month (4-bit) in the same encoding that stage consumes: day 1..31, month 1..12.
- It includes a tick prescaler, Gregorian leap-year handling, a validated date-load port, and rollover strobes.

---
 rtl/calendar_pkg.sv | 25 ++
 rtl/month_last_day.sv | 22 ++
 rtl/calendar_date_counter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared widths, month constants and Gregorian leap-year rule
package calendar_pkg;

  localparam int DAY_W = 5;
  localparam int MON_W = 4;

  localparam logic [MON_W-1:0] JAN = 4'd1;
  localparam logic [MON_W-1:0] FEB = 4'd2;
  localparam logic [MON_W-1:0] MAR = 4'd3;
  localparam logic [MON_W-1:0] APR = 4'd4;
  localparam logic [MON_W-1:0] MAY = 4'd5;
  localparam logic [MON_W-1:0] JUN = 4'd6;
  localparam logic [MON_W-1:0] JUL = 4'd7;
  localparam logic [MON_W-1:0] AUG = 4'd8;
  localparam logic [MON_W-1:0] SEP = 4'd9;
  localparam logic [MON_W-1:0] OCT = 4'd10;
  localparam logic [MON_W-1:0] NOV = 4'd11;
  localparam logic [MON_W-1:0] DEC = 4'd12;

  function automatic logic is_leap(input logic [31:0] year);
    return ((year % 32'd4) == 32'd0) &&
           (((year % 32'd100) != 32'd0) || ((year % 32'd400) == 32'd0));
  endfunction

endpackage

// File: rtl/month_last_day.sv
// rtl/month_last_day.sv - number of days in a given month/year
// Out-of-range months report 31; callers that care validate the month themselves.
module month_last_day
  import calendar_pkg::*;
#(
  parameter int YEAR_W = 12
) (
  input  logic [MON_W-1:0]  mon_i,
  input  logic [YEAR_W-1:0] year_i,
  output logic [DAY_W-1:0]  last_day_o
);

  always_comb begin
    last_day_o = 5'd31;
    case (mon_i)
      APR, JUN, SEP, NOV: last_day_o = 5'd30;
      FEB:                last_day_o = is_leap(32'(year_i)) ? 5'd29 : 5'd28;
      default:            last_day_o = 5'd31;
    endcase
  end

endmodule

// File: rtl/calendar_date_counter.sv
// rtl/calendar_date_counter.sv - registered day/month/year counter with prescaler, load and rollover strobes
module calendar_date_counter
  import calendar_pkg::*;
#(
  parameter int YEAR_W        = 12,
  parameter int TICKS_PER_DAY = 1,
  parameter int RESET_YEAR    = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_in,
  input  logic              load,
  input  logic [DAY_W-1:0]  set_day,
  input  logic [MON_W-1:0]  set_mon,
  input  logic [YEAR_W-1:0] set_year,
  output logic [DAY_W-1:0]  day,
  output logic [MON_W-1:0]  mon,
  output logic [YEAR_W-1:0] year,
  output logic [DAY_W-1:0]  last_day,
  output logic              day_adv,
  output logic              new_month,
  output logic              new_year,
  output logic              load_err
);

  localparam int PW = (TICKS_PER_DAY > 1) ? $clog2(TICKS_PER_DAY) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_DAY - 1);

  logic [DAY_W-1:0]  day_q, day_d;
  logic [MON_W-1:0]  mon_q, mon_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              day_adv_q, day_adv_d;
  logic              new_month_q, new_month_d;
  logic              new_year_q, new_year_d;
  logic              load_err_q, load_err_d;

  logic [DAY_W-1:0]  cur_last_day;
  logic [DAY_W-1:0]  set_last_day;
  logic              set_valid;
  logic              advance;

  month_last_day #(.YEAR_W(YEAR_W)) u_cur_last_day (
    .mon_i      (mon_q),
    .year_i     (year_q),
    .last_day_o (cur_last_day)
  );

  // Separate instance so a load is judged against its own month/year, not today's.
  month_last_day #(.YEAR_W(YEAR_W)) u_set_last_day (
    .mon_i      (set_mon),
    .year_i     (set_year),
    .last_day_o (set_last_day)
  );

  assign set_valid = (set_mon >= JAN) && (set_mon <= DEC) &&
                     (set_day != '0) && (set_day <= set_last_day);
  assign advance   = tick_in && (presc_q == PRESC_MAX);

  always_comb begin
    day_d       = day_q;
    mon_d       = mon_q;
    year_d      = year_q;
    presc_d     = presc_q;
    day_adv_d   = 1'b0;
    new_month_d = 1'b0;
    new_year_d  = 1'b0;
    load_err_d  = 1'b0;
    if (load) begin
      // A load swallows any coincident tick; a rejected load leaves the prescaler alone.
      if (set_valid) begin
        day_d   = set_day;
        mon_d   = set_mon;
        year_d  = set_year;
        presc_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick_in) begin
      if (advance) begin
        presc_d   = '0;
        day_adv_d = 1'b1;
        if (day_q < cur_last_day) begin
          day_d = day_q + DAY_W'(1);
        end else begin
          day_d       = DAY_W'(1);
          new_month_d = 1'b1;
          if (mon_q < DEC) begin
            mon_d = mon_q + MON_W'(1);
          end else begin
            mon_d      = JAN;
            year_d     = year_q + YEAR_W'(1);
            new_year_d = 1'b1;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      day_q       <= DAY_W'(1);
      mon_q       <= JAN;
      year_q      <= YEAR_W'(RESET_YEAR);
      presc_q     <= '0;
      day_adv_q   <= 1'b0;
      new_month_q <= 1'b0;
      new_year_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      day_q       <= day_d;
      mon_q       <= mon_d;
      year_q      <= year_d;
      presc_q     <= presc_d;
      day_adv_q   <= day_adv_d;
      new_month_q <= new_month_d;
      new_year_q  <= new_year_d;
      load_err_q  <= load_err_d;
    end
  end

  assign day       = day_q;
  assign mon       = mon_q;
  assign year      = year_q;
  assign last_day  = cur_last_day;
  assign day_adv   = day_adv_q;
  assign new_month = new_month_q;
  assign new_year  = new_year_q;
  assign load_err  = load_err_q;

endmodule
